serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 145 ++++++++++++++
 tb/tb_serial_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// Parallel-to-serial transmitter. A DATA_W-bit payload is accepted on a
// valid/ready handshake and sent as one frame on tx_o: a low start bit,
// DATA_W data bits LSB first, and a high stop bit. Every bit is held for
// CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters
//   DATA_W        payload width in bits (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous, active-high reset
//   data_i   in   parallel payload, captured only on handshake
//   valid_i  in   payload available
//   ready_o  out  block can accept a payload this cycle (IDLE only)
//   tx_o     out  registered serial line, idle-high
//   busy_o   out  frame in progress (START, DATA or STOP)
//   done_o   out  one-cycle pulse in the first IDLE cycle after STOP
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    // Counter widths never drop below one bit, so CLKS_PER_BIT=1 or
    // DATA_W=1 still give legal vectors.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic              tx_q;
    logic              done_q;
    logic              bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (cnt_q == CNT_LAST);

    // Next shift-register value: the following data bit moves into bit 0.
    assign shreg_d = shreg_q >> 1;

    // NOTE: every register below is written with <= so all state updates
    // see the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is tested first, so it overrides any handshake or
        // frame in flight on the same edge, and every register (including
        // the shift register) returns to a known value.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // ready_o is high in IDLE, so valid_i alone completes
                    // the handshake. tx_q goes low now so that the first
                    // START cycle is the one right after this edge.
                    if (valid_i) begin
                        shreg_q <= data_i;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            shreg_q <= shreg_d;
                            tx_q    <= shreg_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign tx_o    = tx_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//
// Self-checking bench for serial_tx. Two instances share one clock:
// index 0 uses CLKS_PER_BIT=4, index 1 uses CLKS_PER_BIT=1, both DATA_W=8.
// Expected line values are pushed to a queue when a handshake is driven and
// popped by a negedge monitor on every busy cycle of either instance (only
// one instance is ever busy at a time). Plain frames come from a vector
// table; back-to-back, interference and mid-frame reset are hand sequences.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    typedef struct {
        int         d;
        logic [7:0] data;
        logic [9:0] frame;   // line bits in send order, bit 0 first
    } vec_t;

    logic            clk;
    logic [1:0]      rst_s;
    logic [1:0]      valid_s;
    logic [1:0][7:0] data_s;
    logic [1:0]      ready_s;
    logic [1:0]      tx_s;
    logic [1:0]      busy_s;
    logic [1:0]      done_s;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;
    bit   mon_en   = 1'b0;
    logic exp_q[$];

    int         done_cnt [2] = '{0, 0};
    int         exp_done [2] = '{0, 0};
    int         idle_run [2] = '{0, 0};
    int         last_gap [2] = '{0, 0};
    logic [1:0] prev_busy    = 2'b00;

    vec_t vecs[5];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_c4 (
        .clk    (clk),
        .reset  (rst_s[0]),
        .data_i (data_s[0]),
        .valid_i(valid_s[0]),
        .ready_o(ready_s[0]),
        .tx_o   (tx_s[0]),
        .busy_o (busy_s[0]),
        .done_o (done_s[0])
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_c1 (
        .clk    (clk),
        .reset  (rst_s[1]),
        .data_i (data_s[1]),
        .valid_i(valid_s[1]),
        .ready_o(ready_s[1]),
        .tx_o   (tx_s[1]),
        .busy_o (busy_s[1]),
        .done_o (done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cpb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Reference frame: start bit 0, payload LSB first, stop bit 1.
    function automatic logic [9:0] frame_of(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

    task automatic push_frame(input int d, input logic [9:0] frame);
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < cpb(d); k++)
                exp_q.push_back(frame[i]);
    endtask

    // Monitor: pops one expected line value per busy cycle and checks
    // idle-line and done-pulse behaviour.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (busy_s[d]) begin
                    check("ready_low_busy", ready_s[d], 0);
                    if (exp_q.size() == 0)
                        check("busy_overrun", busy_s[d], 0);
                    else
                        check("tx_bit", tx_s[d], exp_q.pop_front());
                end else begin
                    check("tx_idle_high", tx_s[d], 1);
                    check("ready_idle", ready_s[d], 1);
                end
                if (done_s[d]) begin
                    check("done_after_frame", {prev_busy[d], exp_q.size() == 0}, 2'b11);
                    done_cnt[d]++;
                end
                if (busy_s[d] && !prev_busy[d]) last_gap[d] = idle_run[d];
                if (busy_s[d]) idle_run[d] = 0;
                else           idle_run[d]++;
                prev_busy[d] = busy_s[d];
            end
        end
    end

    // Called at posedge+1. Raises valid, waits for ready, lets the
    // handshake edge pass and queues the expected frame.
    task automatic start_frame(input int d, input logic [7:0] data,
                               input logic [9:0] frame, input bit keep_valid);
        valid_s[d] = 1'b1;
        data_s[d]  = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_s[d]) break;
        end
        check("handshake_ready", ready_s[d], 1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        push_frame(d, frame);
        if (!keep_valid) valid_s[d] = 1'b0;
        check("start_next_cycle", {busy_s[d], tx_s[d]}, 2'b10);
    endtask

    // Waits for done_o and checks it lands on frame cycle 10*CPB+1.
    task automatic wait_done(input int d);
        exp_done[d]++;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_s[d]) begin
                check("done_cycle", cyc - hs_cyc + 1, 10 * cpb(d) + 1);
                break;
            end
        end
        check("done_seen", done_s[d], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0] = '{d: 0, data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{d: 0, data: 8'h5A, frame: 10'b1010110100};
        vecs[2] = '{d: 0, data: 8'h81, frame: 10'b1100000010};
        vecs[3] = '{d: 1, data: 8'h01, frame: 10'b1000000010};
        vecs[4] = '{d: 1, data: 8'hA5, frame: 10'b1101001010};

        // Reset for two cycles with valid high: the handshake must be dropped.
        rst_s     = 2'b11;
        valid_s   = 2'b11;
        data_s[0] = 8'hFF;
        data_s[1] = 8'hFF;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                check("rst_tx", tx_s[d], 1);
                check("rst_ready", ready_s[d], 1);
                check("rst_busy", busy_s[d], 0);
                check("rst_done", done_s[d], 0);
            end
        end
        rst_s   = 2'b00;
        valid_s = 2'b00;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("post_rst_busy", busy_s, 2'b00);

        // Table-driven single frames on both instances.
        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].d, vecs[i].data, vecs[i].frame, 1'b0);
            wait_done(vecs[i].d);
            repeat (3) @(posedge clk);
            #1;
        end

        // Back-to-back: valid held high for 0x00 then 0xFF.
        base = done_cnt[0];
        start_frame(0, 8'h00, frame_of(8'h00), 1'b1);
        data_s[0] = 8'hFF;
        exp_done[0]++;
        start_frame(0, 8'hFF, frame_of(8'hFF), 1'b0);
        wait_done(0);
        @(posedge clk);
        #1;
        check("b2b_gap", last_gap[0], 1);
        check("b2b_done_count", done_cnt[0] - base, 2);
        repeat (2) @(posedge clk);
        #1;

        // Mid-frame interference: valid pulses and data changes are ignored.
        start_frame(0, 8'h3C, frame_of(8'h3C), 1'b0);
        repeat (8) @(posedge clk);
        #1;
        data_s[0]  = 8'hFF;
        valid_s[0] = 1'b1;
        @(negedge clk);
        check("interf_ready", ready_s[0], 0);
        @(posedge clk);
        #1;
        valid_s[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        valid_s[0] = 1'b1;
        @(negedge clk);
        check("interf_ready2", ready_s[0], 0);
        @(posedge clk);
        #1;
        valid_s[0] = 1'b0;
        wait_done(0);
        repeat (2) @(posedge clk);
        #1;

        // Reset during data bit 3 (frame cycles 17..20), then a clean 0x5A.
        base = done_cnt[0];
        start_frame(0, 8'hC3, frame_of(8'hC3), 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        exp_q.delete();
        check("abort_tx", tx_s[0], 1);
        check("abort_ready", ready_s[0], 1);
        check("abort_busy", busy_s[0], 0);
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt[0] - base, 0);
        start_frame(0, 8'h5A, frame_of(8'h5A), 1'b0);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;

        check("queue_drained", exp_q.size(), 0);
        check("done_total_c4", done_cnt[0], exp_done[0]);
        check("done_total_c1", done_cnt[1], exp_done[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
